line_buffer_feeder: RTL

//   Write-side sequencer for the back-projection line buffer. Accepts filtered

---
 rtl/line_buffer_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/line_buffer_feeder.sv
// Write-side sequencer for the back-projection line buffer.
// Takes filtered samples over a valid/ready stream and drives the buffer's
// shift_in/enable pair. After each line it appends zero padding to flush the
// tap chain. It flags when the first sample has reached the last tap, and it
// pulses done once per line.
module line_buffer_feeder #(
  parameter int pNoTaps     = 4,
  parameter int pTapsWidth  = 3,
  parameter int pDataLength = 16,
  parameter int pLineLength = pNoTaps * pTapsWidth,
  parameter int pPadLength  = pTapsWidth
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [pDataLength-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   hold,
  output logic [pDataLength-1:0] shift_out,
  output logic                   shift_enable,
  output logic                   primed,
  output logic                   busy,
  output logic                   done
);

  localparam int pPrimeCount = (pNoTaps - 1) * pTapsWidth + 1;
  localparam int kCountWidth = $clog2(pLineLength + pPadLength + 1);

  // Counter values seen while the last data shift, the last pad shift and the
  // priming shift are being issued. The counter still holds the pre-increment
  // value at that point.
  localparam logic [kCountWidth-1:0] kLastData  = kCountWidth'(pLineLength - 1);
  localparam logic [kCountWidth-1:0] kLastShift = kCountWidth'(pLineLength + pPadLength - 1);
  localparam logic [kCountWidth-1:0] kPrimeIdx  = kCountWidth'(pPrimeCount - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [kCountWidth-1:0] count_q, count_d;
  logic [pDataLength-1:0] shiftData_q, shiftData_d;
  logic                   shiftEn_q, shiftEn_d;
  logic                   primed_q, primed_d;

  logic                   accept;
  logic                   issue;
  logic [pDataLength-1:0] issueData;

  // hold gates acceptance directly, so no sample is taken while a stall is
  // pending. The sample is accepted the same cycle hold drops.
  assign in_ready = (state_q == STREAM) && !hold;
  assign accept   = in_valid && in_ready;

  assign shift_out    = shiftData_q;
  assign shift_enable = shiftEn_q;
  assign primed       = primed_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

  // Next-state logic: sequence the line, issue shifts and track priming.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shiftData_d = shiftData_q;
    primed_d    = primed_q;
    issue       = 1'b0;
    issueData   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d  = '0;
          primed_d = 1'b0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          issue     = 1'b1;
          issueData = in_data;
          if (count_q == kLastData) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        if (!hold) begin
          issue     = 1'b1;
          issueData = '0;
          if (count_q == kLastShift) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      count_d     = count_q + kCountWidth'(1);
      shiftData_d = issueData;
      if (count_q >= kPrimeIdx) begin
        primed_d = 1'b1;
      end
    end

    shiftEn_d = issue;
  end

  // State and output registers; reset abandons any line in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shiftData_q <= '0;
      shiftEn_q   <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shiftData_q <= shiftData_d;
      shiftEn_q   <= shiftEn_d;
      primed_q    <= primed_d;
    end
  end

endmodule
